// File: rtl/bullet_engine_if.sv
// rtl/bullet_engine_if.sv - world map BRAM read port shared by the bullet engine and the map memory
// The memory side returns data one clock after it samples map_addr.
interface bullet_engine_if;
  logic [13:0] map_addr;
  logic [1:0]  map_data;

  modport master (output map_addr, input map_data);
  modport slave  (input map_addr, output map_data);
endinterface

// File: rtl/bullet_engine.sv
// rtl/bullet_engine.sv - single-bullet projectile engine: launch, map stepping, obstacle stop, opponent hit
// One bullet per owner; a step is ADDR -> RD -> CHECK, then FLY pads the step out to MOVE_DIV clocks.
module bullet_engine #(
  parameter int MOVE_DIV   = 1250000,
  parameter int HIT_RADIUS = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             fire,
  input  logic [7:0]       LocX,
  input  logic [7:0]       LocY,
  input  logic [7:0]       BotInfo,
  input  logic [7:0]       opp_LocX,
  input  logic [7:0]       opp_LocY,
  bullet_engine_if.master  mem,
  input  logic [6:0]       world_row,
  input  logic [6:0]       world_column,
  input  logic             out_of_map,
  output logic             bullet_flag,
  output logic [6:0]       bullet_x,
  output logic [6:0]       bullet_y,
  output logic             bullet_active,
  output logic             hit,
  output logic [7:0]       hit_count
);

  localparam int             CW      = $clog2(MOVE_DIV + 1);
  localparam logic [CW-1:0]  CNT_END = CW'(MOVE_DIV - 4);
  localparam logic [6:0]     RADIUS  = 7'(HIT_RADIUS);

  typedef enum logic [2:0] {IDLE, ADDR, RD, CHECK, FLY} state_t;

  state_t          state, state_n;
  logic            fire_q;
  logic [2:0]      heading;
  logic [6:0]      base_x, base_y;
  logic [CW-1:0]   step_cnt;
  logic [7:0]      dx, dy, nx8, ny8;
  logic [6:0]      adx, ady;
  logic            launch, off_map, obstacle, near;
  logic            unused_bits;

  assign unused_bits = ^{LocX[7], LocY[7], BotInfo[7:3], opp_LocX[7], opp_LocY[7], mem.map_data[0]};

  always_comb begin
    dx = 8'h00;
    dy = 8'h00;
    case (heading)
      3'd0: begin dx = 8'h00; dy = 8'hFF; end
      3'd1: begin dx = 8'h01; dy = 8'hFF; end
      3'd2: begin dx = 8'h01; dy = 8'h00; end
      3'd3: begin dx = 8'h01; dy = 8'h01; end
      3'd4: begin dx = 8'h00; dy = 8'h01; end
      3'd5: begin dx = 8'hFF; dy = 8'h01; end
      3'd6: begin dx = 8'hFF; dy = 8'h00; end
      3'd7: begin dx = 8'hFF; dy = 8'hFF; end
      default: begin dx = 8'h00; dy = 8'h00; end
    endcase
  end

  // Bit 7 of the widened sum flags both -1 and 128 as leaving the map.
  assign nx8      = {1'b0, base_x} + dx;
  assign ny8      = {1'b0, base_y} + dy;
  assign off_map  = nx8[7] | ny8[7];
  assign adx      = (nx8[6:0] >= opp_LocX[6:0]) ? nx8[6:0] - opp_LocX[6:0] : opp_LocX[6:0] - nx8[6:0];
  assign ady      = (ny8[6:0] >= opp_LocY[6:0]) ? ny8[6:0] - opp_LocY[6:0] : opp_LocY[6:0] - ny8[6:0];
  assign near     = (adx <= RADIUS) && (ady <= RADIUS);
  assign obstacle = mem.map_data[1];
  assign launch   = fire & ~fire_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (launch) state_n = ADDR;
      ADDR:    state_n = off_map ? IDLE : RD;
      RD:      state_n = CHECK;
      CHECK:   state_n = (obstacle || near) ? IDLE : FLY;
      FLY:     if (step_cnt == CNT_END) state_n = ADDR;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fire_q        <= 1'b0;
      heading       <= 3'd0;
      base_x        <= 7'd0;
      base_y        <= 7'd0;
      step_cnt      <= '0;
      mem.map_addr  <= 14'd0;
      bullet_x      <= 7'd0;
      bullet_y      <= 7'd0;
      bullet_active <= 1'b0;
      bullet_flag   <= 1'b0;
      hit           <= 1'b0;
      hit_count     <= 8'd0;
    end else begin
      fire_q      <= fire;
      hit         <= 1'b0;
      bullet_flag <= bullet_active & ~out_of_map &
                     (world_row == bullet_y) & (world_column == bullet_x);
      if (clear) begin
        bullet_active <= 1'b0;
        hit_count     <= 8'd0;
      end else begin
        case (state)
          IDLE: if (launch) begin
            heading <= BotInfo[2:0];
            base_x  <= LocX[6:0];
            base_y  <= LocY[6:0];
          end
          ADDR: begin
            if (off_map) bullet_active <= 1'b0;
            else         mem.map_addr  <= {ny8[6:0], nx8[6:0]};
          end
          CHECK: begin
            if (obstacle) begin
              bullet_active <= 1'b0;
            end else begin
              bullet_x <= nx8[6:0];
              bullet_y <= ny8[6:0];
              base_x   <= nx8[6:0];
              base_y   <= ny8[6:0];
              if (near) begin
                hit           <= 1'b1;
                bullet_active <= 1'b0;
                if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
              end else begin
                bullet_active <= 1'b1;
                step_cnt      <= '0;
              end
            end
          end
          FLY:     step_cnt <= step_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bullet_engine.sv
// tb/tb_bullet_engine.sv - randomized self-checking bench for bullet_engine against an event-scheduled model
// The model predicts when each step resolves from launch time and MOVE_DIV rather than tracking FSM states.
module tb_bullet_engine;
  localparam int MD  = 8;
  localparam int RAD = 2;

  logic clk = 1'b0, rstn = 1'b0, clear = 1'b0, fire = 1'b0;
  logic [7:0] LocX = 0, LocY = 0, BotInfo = 0, opp_LocX = 0, opp_LocY = 0;
  logic [6:0] world_row = 0, world_column = 0;
  logic out_of_map = 1'b0;
  logic bullet_flag, bullet_active, hit;
  logic [6:0] bullet_x, bullet_y;
  logic [7:0] hit_count;
  logic [1:0] map [0:16383];
  int checks = 0, errors = 0;

  bullet_engine_if mif();

  bullet_engine #(.MOVE_DIV(MD), .HIT_RADIUS(RAD)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .fire(fire),
    .LocX(LocX), .LocY(LocY), .BotInfo(BotInfo), .opp_LocX(opp_LocX), .opp_LocY(opp_LocY),
    .mem(mif.master), .world_row(world_row), .world_column(world_column), .out_of_map(out_of_map),
    .bullet_flag(bullet_flag), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active), .hit(hit), .hit_count(hit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mif.map_data <= map[mif.map_addr];

  // Behavioural model
  int DXT [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int DYT [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
  int m_cyc = 0, m_ev = 0, m_kind = 0, m_bx = 0, m_by = 0, m_dir = 0, m_x = 0, m_y = 0, m_cnt = 0;
  bit m_busy = 0, m_active = 0, m_hit = 0, m_flag = 0, m_fprev = 0;

  task automatic schedule(input int ref_cyc);
    int nx, ny;
    nx = m_bx + DXT[m_dir];
    ny = m_by + DYT[m_dir];
    if (nx < 0 || nx > 127 || ny < 0 || ny > 127) begin m_kind = 0; m_ev = ref_cyc + 1; end
    else begin m_kind = 1; m_ev = ref_cyc + 3; end
  endtask

  task automatic resolve_step();
    int nx, ny, ax, ay;
    nx = m_bx + DXT[m_dir];
    ny = m_by + DYT[m_dir];
    if (m_kind == 0) begin
      m_busy = 0; m_active = 0;
    end else if (map[ny * 128 + nx][1]) begin
      m_busy = 0; m_active = 0;
    end else begin
      m_x = nx; m_y = ny; m_active = 1;
      ax = nx - int'(opp_LocX[6:0]); if (ax < 0) ax = -ax;
      ay = ny - int'(opp_LocY[6:0]); if (ay < 0) ay = -ay;
      if (ax <= RAD && ay <= RAD) begin
        m_hit = 1; m_active = 0; m_busy = 0;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_bx = nx; m_by = ny;
        schedule(m_cyc + MD - 3);
      end
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 0; m_active = 0; m_hit = 0; m_flag = 0; m_fprev = 0;
      m_x = 0; m_y = 0; m_cnt = 0;
    end else begin
      bit was_busy;
      m_cyc++;
      m_flag = m_active && !out_of_map && int'(world_row) == m_y && int'(world_column) == m_x;
      m_hit = 0;
      if (clear) begin
        m_busy = 0; m_active = 0; m_cnt = 0;
      end else begin
        was_busy = m_busy;
        if (m_busy && m_cyc == m_ev) resolve_step();
        if (!was_busy && fire && !m_fprev) begin
          m_dir = int'(BotInfo[2:0]); m_bx = int'(LocX[6:0]); m_by = int'(LocY[6:0]);
          m_busy = 1;
          schedule(m_cyc);
        end
      end
      m_fprev = fire;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] act, input int mdl, input int exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  always @(negedge clk) begin
    chk("active", bullet_active, m_active);
    chk("bx", bullet_x, m_x);
    chk("by", bullet_y, m_y);
    chk("hit", hit, m_hit);
    chk("count", hit_count, m_cnt);
    chk("flag", bullet_flag, m_flag);
  end

  task automatic pulse_fire();
    @(negedge clk) fire = 1'b1;
    @(negedge clk) fire = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  task automatic setup(input int x, input int y, input int h, input int ox, input int oy);
    LocX = 8'(x); LocY = 8'(y); BotInfo = 8'(h); opp_LocX = 8'(ox); opp_LocY = 8'(oy);
  endtask

  initial begin
    int n;
    int t4x [4] = '{0, 0, 0, 127};
    int t4y [4] = '{0, 0, 0, 64};
    int t4h [4] = '{6, 0, 7, 2};
    for (int i = 0; i < 16384; i++) map[i] = 2'b00;
    repeat (3) @(negedge clk);
    lit("rst_active", bullet_active, m_active, 0);
    lit("rst_count", hit_count, m_cnt, 0);
    chk("rst_addr", mif.map_addr, 0);
    chk("rst_x", bullet_x, 0);
    rstn = 1'b1;

    // Straight east flight on an empty map
    setup(10, 10, 2, 100, 100);
    pulse_fire();
    repeat (2) @(negedge clk);
    lit("t1_pre", bullet_active, m_active, 0);
    @(negedge clk);
    lit("t1_act", bullet_active, m_active, 1);
    lit("t1_x", bullet_x, m_x, 11);
    lit("t1_y", bullet_y, m_y, 10);
    repeat (MD) @(negedge clk);
    lit("t1_x2", bullet_x, m_x, 12);
    pulse_clear();
    lit("t1_clr", bullet_active, m_active, 0);

    // NE into an obstacle
    map[18 * 128 + 22] = 2'b10;
    setup(20, 20, 1, 100, 100);
    pulse_fire();
    repeat (3) @(negedge clk);
    lit("t2_x", bullet_x, m_x, 21);
    lit("t2_y", bullet_y, m_y, 19);
    repeat (MD) @(negedge clk);
    lit("t2_stop", bullet_active, m_active, 0);
    lit("t2_xs", bullet_x, m_x, 21);
    lit("t2_hit", hit, m_hit, 0);

    // Opponent hit on the second step
    setup(5, 50, 2, 9, 51);
    pulse_fire();
    repeat (3) @(negedge clk);
    lit("t3_x1", bullet_x, m_x, 6);
    repeat (MD) @(negedge clk);
    lit("t3_hit", hit, m_hit, 1);
    lit("t3_cnt", hit_count, m_cnt, 1);
    lit("t3_act", bullet_active, m_active, 0);
    lit("t3_x2", bullet_x, m_x, 7);
    @(negedge clk);
    lit("t3_hit_end", hit, m_hit, 0);

    // Saturation of the hit counter
    setup(5, 50, 2, 7, 50);
    for (int i = 0; i < 260; i++) begin
      pulse_fire();
      repeat (3) @(negedge clk);
    end
    lit("t3_sat", hit_count, m_cnt, 255);

    // Launches that leave the map immediately
    pulse_clear();
    for (int i = 0; i < 4; i++) begin
      setup(t4x[i], t4y[i], t4h[i], 100, 100);
      pulse_fire();
      repeat (4) @(negedge clk);
      lit("t4_noact", bullet_active, m_active, 0);
    end

    // Held fire, ignored mid-flight edge, clear with fire held
    setup(10, 10, 2, 100, 100);
    @(negedge clk) fire = 1'b1;
    repeat (5) @(negedge clk);
    fire = 1'b0;
    @(negedge clk) fire = 1'b1;
    repeat (6) @(negedge clk);
    lit("t5_fly", bullet_active, m_active, 1);
    pulse_clear();
    lit("t5_clr", bullet_active, m_active, 0);
    lit("t5_cnt", hit_count, m_cnt, 0);
    repeat (10) @(negedge clk);
    lit("t5_norelaunch", bullet_active, m_active, 0);
    fire = 1'b0;

    // Asynchronous reset while the map read is outstanding
    pulse_fire();
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_addr", mif.map_addr, 0);
    chk("t5_rst_act", bullet_active, 0);
    chk("t5_rst_x", bullet_x, 0);
    chk("t5_rst_cnt", hit_count, 0);
    @(negedge clk) rstn = 1'b1;

    // Pixel flag at bullet (30,40)
    setup(29, 40, 2, 100, 100);
    pulse_fire();
    repeat (3) @(negedge clk);
    world_row = 7'd40; world_column = 7'd30; out_of_map = 1'b0;
    @(negedge clk);
    lit("t6_flag", bullet_flag, m_flag, 1);
    out_of_map = 1'b1;
    @(negedge clk);
    lit("t6_oom", bullet_flag, m_flag, 0);
    out_of_map = 1'b0; world_column = 7'd31;
    @(negedge clk);
    lit("t6_miss", bullet_flag, m_flag, 0);
    world_column = 7'd30;
    @(negedge clk);
    lit("t6_flag2", bullet_flag, m_flag, 1);
    pulse_clear();

    // Randomized scenes over a littered map
    for (int i = 0; i < 1500; i++) map[$urandom_range(0, 16383)] = 2'($urandom_range(1, 3));
    for (int r = 0; r < 250; r++) begin
      @(negedge clk);
      LocX = 8'($urandom); LocY = 8'($urandom); BotInfo = 8'($urandom);
      opp_LocX = 8'($urandom); opp_LocY = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        opp_LocX[6:0] = LocX[6:0] + 7'($urandom_range(0, 12)) - 7'd6;
        opp_LocY[6:0] = LocY[6:0] + 7'($urandom_range(0, 12)) - 7'd6;
      end
      fire = 1'b1;
      @(negedge clk) fire = 1'b0;
      n = $urandom_range(1, 60);
      repeat (n) begin
        @(negedge clk);
        world_row    = ($urandom_range(0, 1) == 1) ? 7'(m_y) : 7'($urandom);
        world_column = ($urandom_range(0, 1) == 1) ? 7'(m_x) : 7'($urandom);
        out_of_map   = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0) fire = ~fire;
        clear = ($urandom_range(0, 150) == 0);
      end
      clear = 1'b0;
      fire  = 1'b0;
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
